// File: rtl/mips_decode_stage.sv
// mips_decode_stage: registered MIPS-I decode stage.
// Decodes one instruction per cycle into a control bundle held in the ID/EX
// register, with valid/ready handshaking, flush, a load-use interlock of
// configurable depth and illegal-instruction flagging.
module mips_decode_stage #(
    parameter int DATA_W   = 32,
    parameter int LU_DEPTH = 1,
    parameter int HALF_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_dest,
    output logic [DATA_W-1:0] out_imm,
    output logic [4:0]        out_shamt,
    output logic [4:0]        out_aluctr,
    output logic              out_regwr,
    output logic              out_alusrc,
    output logic              out_memwr,
    output logic              out_memtoreg,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_jumpreg,
    output logic              out_link,
    output logic              out_shamtctr,
    output logic              out_dmsignext,
    output logic [1:0]        out_bytewidth,
    output logic              out_illegal
);

    // primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J    = 6'b000010, OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100, OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ = 6'b000110, OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110, OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB   = 6'b100000, OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW   = 6'b100011, OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU  = 6'b100101, OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH   = 6'b101001, OP_SW    = 6'b101011;

    // SPECIAL function codes
    localparam logic [5:0] FN_SLL  = 6'b000000, FN_SRL  = 6'b000010, FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100, FN_SRLV = 6'b000110, FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000, FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000, FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010, FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100, FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110, FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010, FN_SLTU = 6'b101011;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD  = 5'b00001, ALU_SUB  = 5'b00010, ALU_AND  = 5'b00011;
    localparam logic [4:0] ALU_OR   = 5'b00100, ALU_XOR  = 5'b00101, ALU_NOR  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b00111, ALU_SLTU = 5'b01000, ALU_SLL  = 5'b01001;
    localparam logic [4:0] ALU_SRL  = 5'b01010, ALU_SRA  = 5'b01011, ALU_BEQ  = 5'b01100;
    localparam logic [4:0] ALU_BNE  = 5'b01101, ALU_BGEZ = 5'b01110, ALU_BGTZ = 5'b01111;
    localparam logic [4:0] ALU_BLEZ = 5'b10000, ALU_BLTZ = 5'b10001, ALU_LUI  = 5'b10010;

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    assign op    = in_instr[31:26];
    assign rs    = in_instr[25:21];
    assign rt    = in_instr[20:16];
    assign rd    = in_instr[15:11];
    assign fn    = in_instr[5:0];
    assign imm16 = in_instr[15:0];

    logic [4:0]        d_aluctr, d_dest;
    logic              d_regwr, d_alusrc, d_memwr, d_memtoreg, d_branch, d_jump;
    logic              d_jumpreg, d_link, d_shamtctr, d_dmsignext, d_illegal;
    logic [1:0]        d_bytewidth;
    logic              d_ext, d_lui, d_load, d_use_rs, d_use_rt;
    logic [DATA_W-1:0] d_imm, sext_imm;

    // Combinational decode of the presented instruction
    always_comb begin
        d_aluctr    = 5'd0;
        d_dest      = 5'd0;
        d_regwr     = 1'b0;
        d_alusrc    = 1'b0;
        d_memwr     = 1'b0;
        d_memtoreg  = 1'b0;
        d_branch    = 1'b0;
        d_jump      = 1'b0;
        d_jumpreg   = 1'b0;
        d_link      = 1'b0;
        d_shamtctr  = 1'b0;
        d_dmsignext = 1'b0;
        d_bytewidth = 2'b00;
        d_illegal   = 1'b0;
        d_ext       = 1'b0;
        d_lui       = 1'b0;
        d_load      = 1'b0;
        d_use_rs    = 1'b1;
        d_use_rt    = 1'b0;
        case (op)
            OP_SPECIAL: begin
                d_dest   = rd;
                d_regwr  = 1'b1;
                d_use_rt = 1'b1;
                case (fn)
                    FN_SLL:  begin d_aluctr = ALU_SLL; d_shamtctr = 1'b1; d_use_rs = 1'b0; end
                    FN_SRL:  begin d_aluctr = ALU_SRL; d_shamtctr = 1'b1; d_use_rs = 1'b0; end
                    FN_SRA:  begin d_aluctr = ALU_SRA; d_shamtctr = 1'b1; d_use_rs = 1'b0; end
                    FN_SLLV: d_aluctr = ALU_SLL;
                    FN_SRLV: d_aluctr = ALU_SRL;
                    FN_SRAV: d_aluctr = ALU_SRA;
                    FN_JR:   begin d_regwr = 1'b0; d_jumpreg = 1'b1; d_use_rt = 1'b0; end
                    FN_JALR: begin d_jumpreg = 1'b1; d_link = 1'b1; d_use_rt = 1'b0; end
                    FN_ADD, FN_ADDU: d_aluctr = ALU_ADD;
                    FN_SUB, FN_SUBU: d_aluctr = ALU_SUB;
                    FN_AND:  d_aluctr = ALU_AND;
                    FN_OR:   d_aluctr = ALU_OR;
                    FN_XOR:  d_aluctr = ALU_XOR;
                    FN_NOR:  d_aluctr = ALU_NOR;
                    FN_SLT:  d_aluctr = ALU_SLT;
                    FN_SLTU: d_aluctr = ALU_SLTU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                d_dest   = rt;
                d_branch = 1'b1;
                d_ext    = 1'b1;
                case (rt)
                    5'b00001: d_aluctr = ALU_BGEZ;
                    5'b00000: d_aluctr = ALU_BLTZ;
                    default:  d_illegal = 1'b1;
                endcase
            end
            OP_J:   begin d_jump = 1'b1; d_use_rs = 1'b0; end
            OP_JAL: begin
                d_jump   = 1'b1;
                d_link   = 1'b1;
                d_dest   = 5'd31;
                d_regwr  = 1'b1;
                d_use_rs = 1'b0;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                d_dest   = rt;
                d_branch = 1'b1;
                d_ext    = 1'b1;
                case (op)
                    OP_BEQ:  begin d_aluctr = ALU_BEQ; d_use_rt = 1'b1; end
                    OP_BNE:  begin d_aluctr = ALU_BNE; d_use_rt = 1'b1; end
                    OP_BLEZ: d_aluctr = ALU_BLEZ;
                    default: d_aluctr = ALU_BGTZ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                d_dest   = rt;
                d_regwr  = 1'b1;
                d_alusrc = 1'b1;
                case (op)
                    OP_ADDI:  begin d_aluctr = ALU_ADD; d_ext = 1'b1; end
                    OP_ADDIU: d_aluctr = ALU_ADD;
                    OP_SLTI:  begin d_aluctr = ALU_SLT; d_ext = 1'b1; end
                    OP_SLTIU: d_aluctr = ALU_SLTU;
                    OP_ANDI:  d_aluctr = ALU_AND;
                    OP_ORI:   d_aluctr = ALU_OR;
                    OP_XORI:  d_aluctr = ALU_XOR;
                    default:  begin d_aluctr = ALU_LUI; d_lui = 1'b1; d_use_rs = 1'b0; end
                endcase
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
                d_dest     = rt;
                d_regwr    = 1'b1;
                d_alusrc   = 1'b1;
                d_ext      = 1'b1;
                d_memtoreg = 1'b1;
                d_load     = 1'b1;
                d_aluctr   = ALU_ADD;
                case (op)
                    OP_LB:   begin d_bytewidth = 2'b01; d_dmsignext = 1'b1; end
                    OP_LBU:  d_bytewidth = 2'b01;
                    OP_LH:   begin d_bytewidth = 2'b10; d_dmsignext = 1'b1; d_illegal = (HALF_EN == 0); end
                    OP_LHU:  begin d_bytewidth = 2'b10; d_illegal = (HALF_EN == 0); end
                    default: d_bytewidth = 2'b11;
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                d_dest   = rt;
                d_alusrc = 1'b1;
                d_ext    = 1'b1;
                d_memwr  = 1'b1;
                d_use_rt = 1'b1;
                d_aluctr = ALU_ADD;
                case (op)
                    OP_SB:   d_bytewidth = 2'b01;
                    OP_SH:   begin d_bytewidth = 2'b10; d_illegal = (HALF_EN == 0); end
                    default: d_bytewidth = 2'b11;
                endcase
            end
            default: d_illegal = 1'b1;
        endcase
        // writes to $0 are discarded
        if (d_dest == 5'd0) d_regwr = 1'b0;
        // an illegal word carries no side effects and no operand dependencies on rt
        if (d_illegal) begin
            d_aluctr    = 5'd0;
            d_dest      = 5'd0;
            d_regwr     = 1'b0;
            d_alusrc    = 1'b0;
            d_memwr     = 1'b0;
            d_memtoreg  = 1'b0;
            d_branch    = 1'b0;
            d_jump      = 1'b0;
            d_jumpreg   = 1'b0;
            d_link      = 1'b0;
            d_shamtctr  = 1'b0;
            d_dmsignext = 1'b0;
            d_bytewidth = 2'b00;
            d_ext       = 1'b0;
            d_lui       = 1'b0;
            d_load      = 1'b0;
            d_use_rt    = 1'b0;
        end
    end

    assign sext_imm = {{(DATA_W-16){imm16[15]}}, imm16};
    assign d_imm    = d_lui ? DATA_W'({imm16, 16'h0000}) :
                      d_ext ? sext_imm : DATA_W'(imm16);

    // load-use scoreboard: entry 0 is the most recently issued load
    logic [LU_DEPTH-1:0] sb_valid_reg;
    logic [4:0]          sb_dest_reg [LU_DEPTH];
    logic [LU_DEPTH-1:0] hit;
    logic                stall, advance, accept;

    generate
        for (genvar gi = 0; gi < LU_DEPTH; gi++) begin : g_hit
            assign hit[gi] = sb_valid_reg[gi] && (sb_dest_reg[gi] != 5'd0) &&
                             ((d_use_rs && (rs == sb_dest_reg[gi])) ||
                              (d_use_rt && (rt == sb_dest_reg[gi])));
        end
    endgenerate

    assign stall    = in_valid & (|hit);
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance & ~stall & ~flush;
    assign accept   = in_valid & ~stall;

    // Scoreboard shifts with the pipeline; flush only forgets the youngest slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LU_DEPTH; i++) begin
                sb_valid_reg[i] <= 1'b0;
                sb_dest_reg[i]  <= 5'd0;
            end
        end else if (flush) begin
            sb_valid_reg[0] <= 1'b0;
        end else if (advance) begin
            sb_valid_reg[0] <= accept & d_load;
            sb_dest_reg[0]  <= d_dest;
            for (int i = 1; i < LU_DEPTH; i++) begin
                sb_valid_reg[i] <= sb_valid_reg[i-1];
                sb_dest_reg[i]  <= sb_dest_reg[i-1];
            end
        end
    end

    // ID/EX register: loads on advance (bubble when stalled), holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_rs        <= 5'd0;
            out_rt        <= 5'd0;
            out_dest      <= 5'd0;
            out_imm       <= '0;
            out_shamt     <= 5'd0;
            out_aluctr    <= 5'd0;
            out_regwr     <= 1'b0;
            out_alusrc    <= 1'b0;
            out_memwr     <= 1'b0;
            out_memtoreg  <= 1'b0;
            out_branch    <= 1'b0;
            out_jump      <= 1'b0;
            out_jumpreg   <= 1'b0;
            out_link      <= 1'b0;
            out_shamtctr  <= 1'b0;
            out_dmsignext <= 1'b0;
            out_bytewidth <= 2'b00;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid     <= accept;
            out_pc        <= in_pc;
            out_rs        <= rs;
            out_rt        <= rt;
            out_dest      <= d_dest;
            out_imm       <= d_imm;
            out_shamt     <= in_instr[10:6];
            out_aluctr    <= d_aluctr;
            out_regwr     <= d_regwr;
            out_alusrc    <= d_alusrc;
            out_memwr     <= d_memwr;
            out_memtoreg  <= d_memtoreg;
            out_branch    <= d_branch;
            out_jump      <= d_jump;
            out_jumpreg   <= d_jumpreg;
            out_link      <= d_link;
            out_shamtctr  <= d_shamtctr;
            out_dmsignext <= d_dmsignext;
            out_bytewidth <= d_bytewidth;
            out_illegal   <= d_illegal;
        end
    end

endmodule

// File: tb/tb_mips_decode_stage.sv
// tb_mips_decode_stage: directed scenarios followed by random traffic, checked
// against a mnemonic-level reference model of the decode stage.
module tb_mips_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs, out_rt, out_dest, out_shamt, out_aluctr;
    logic        out_regwr, out_alusrc, out_memwr, out_memtoreg, out_branch, out_jump;
    logic        out_jumpreg, out_link, out_shamtctr, out_dmsignext, out_illegal;
    logic [1:0]  out_bytewidth;

    logic        nh_in_ready, nh_out_valid;
    logic [31:0] nh_out_pc, nh_out_imm;
    logic [4:0]  nh_out_rs, nh_out_rt, nh_out_dest, nh_out_shamt, nh_out_aluctr;
    logic        nh_out_regwr, nh_out_alusrc, nh_out_memwr, nh_out_memtoreg, nh_out_branch;
    logic        nh_out_jump, nh_out_jumpreg, nh_out_link, nh_out_shamtctr, nh_out_dmsignext;
    logic        nh_out_illegal;
    logic [1:0]  nh_out_bytewidth;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_decode_stage #(.DATA_W(32), .LU_DEPTH(1), .HALF_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt),
        .out_dest(out_dest), .out_imm(out_imm), .out_shamt(out_shamt), .out_aluctr(out_aluctr),
        .out_regwr(out_regwr), .out_alusrc(out_alusrc), .out_memwr(out_memwr),
        .out_memtoreg(out_memtoreg), .out_branch(out_branch), .out_jump(out_jump),
        .out_jumpreg(out_jumpreg), .out_link(out_link), .out_shamtctr(out_shamtctr),
        .out_dmsignext(out_dmsignext), .out_bytewidth(out_bytewidth), .out_illegal(out_illegal)
    );

    mips_decode_stage #(.DATA_W(32), .LU_DEPTH(1), .HALF_EN(0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nh_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(nh_out_valid),
        .out_ready(out_ready), .out_pc(nh_out_pc), .out_rs(nh_out_rs), .out_rt(nh_out_rt),
        .out_dest(nh_out_dest), .out_imm(nh_out_imm), .out_shamt(nh_out_shamt),
        .out_aluctr(nh_out_aluctr), .out_regwr(nh_out_regwr), .out_alusrc(nh_out_alusrc),
        .out_memwr(nh_out_memwr), .out_memtoreg(nh_out_memtoreg), .out_branch(nh_out_branch),
        .out_jump(nh_out_jump), .out_jumpreg(nh_out_jumpreg), .out_link(nh_out_link),
        .out_shamtctr(nh_out_shamtctr), .out_dmsignext(nh_out_dmsignext),
        .out_bytewidth(nh_out_bytewidth), .out_illegal(nh_out_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs, rt, dest, shamt, aluctr;
        logic [31:0] imm;
        logic        regwr, alusrc, memwr, memtoreg, branch, jump, jumpreg, link, shamtctr, dmsignext;
        logic [1:0]  bw;
        logic        ill;
    } bundle_t;

    typedef enum int {
        M_ILL, M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_JALR,
        M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_BLTZ, M_BGEZ, M_J, M_JAL, M_BEQ, M_BNE, M_BLEZ, M_BGTZ,
        M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
        M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW
    } mn_t;

    // model state: expected output register and the list of recent load targets (-1 = empty)
    bundle_t m_bundle;
    logic    m_valid;
    int      sbq[$];
    logic    seen_rdy;

    function automatic mn_t classify(input logic [31:0] w, input bit half);
        mn_t m;
        m = M_ILL;
        case (int'(w[31:26]))
            0: case (int'(w[5:0]))
                   0: m = M_SLL;   2: m = M_SRL;   3: m = M_SRA;   4: m = M_SLLV;
                   6: m = M_SRLV;  7: m = M_SRAV;  8: m = M_JR;    9: m = M_JALR;
                   32: m = M_ADD;  33: m = M_ADDU; 34: m = M_SUB;  35: m = M_SUBU;
                   36: m = M_AND;  37: m = M_OR;   38: m = M_XOR;  39: m = M_NOR;
                   42: m = M_SLT;  43: m = M_SLTU;
                   default: m = M_ILL;
               endcase
            1: m = (w[20:16] == 5'd1) ? M_BGEZ : (w[20:16] == 5'd0) ? M_BLTZ : M_ILL;
            2: m = M_J;     3: m = M_JAL;   4: m = M_BEQ;   5: m = M_BNE;
            6: m = M_BLEZ;  7: m = M_BGTZ;  8: m = M_ADDI;  9: m = M_ADDIU;
            10: m = M_SLTI; 11: m = M_SLTIU; 12: m = M_ANDI; 13: m = M_ORI;
            14: m = M_XORI; 15: m = M_LUI;  32: m = M_LB;   33: m = M_LH;
            35: m = M_LW;   36: m = M_LBU;  37: m = M_LHU;  40: m = M_SB;
            41: m = M_SH;   43: m = M_SW;
            default: m = M_ILL;
        endcase
        if (!half && (m inside {M_LH, M_LHU, M_SH})) m = M_ILL;
        return m;
    endfunction

    function automatic logic [4:0] alu_code(input mn_t m);
        case (m)
            M_ADD, M_ADDU, M_ADDI, M_ADDIU, M_LW, M_SW, M_LB, M_LBU, M_SB, M_LH, M_LHU, M_SH: return 5'd1;
            M_SUB, M_SUBU: return 5'd2;
            M_AND, M_ANDI: return 5'd3;
            M_OR, M_ORI:   return 5'd4;
            M_XOR, M_XORI: return 5'd5;
            M_NOR:         return 5'd6;
            M_SLT, M_SLTI: return 5'd7;
            M_SLTU, M_SLTIU: return 5'd8;
            M_SLL, M_SLLV: return 5'd9;
            M_SRL, M_SRLV: return 5'd10;
            M_SRA, M_SRAV: return 5'd11;
            M_BEQ:  return 5'd12;
            M_BNE:  return 5'd13;
            M_BGEZ: return 5'd14;
            M_BGTZ: return 5'd15;
            M_BLEZ: return 5'd16;
            M_BLTZ: return 5'd17;
            M_LUI:  return 5'd18;
            default: return 5'd0;
        endcase
    endfunction

    function automatic void ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit half,
                                       output bundle_t b, output bit urs, output bit urt, output bit ld);
        mn_t m;
        bit rfmt, ralu, shft, ialu, st, br, sext;
        m    = classify(w, half);
        ralu = m inside {M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU};
        shft = m inside {M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV};
        rfmt = ralu || shft || m == M_JR || m == M_JALR;
        ialu = m inside {M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI};
        ld   = m inside {M_LB, M_LBU, M_LH, M_LHU, M_LW};
        st   = m inside {M_SB, M_SH, M_SW};
        br   = m inside {M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BGEZ, M_BLTZ};
        sext = (m inside {M_ADDI, M_SLTI}) || ld || st || br;
        b        = '0;
        b.pc     = pc;
        b.rs     = w[25:21];
        b.rt     = w[20:16];
        b.shamt  = w[10:6];
        b.aluctr = alu_code(m);
        if (m == M_LUI)  b.imm = {w[15:0], 16'h0000};
        else if (sext)   b.imm = {{16{w[15]}}, w[15:0]};
        else             b.imm = {16'h0000, w[15:0]};
        if (rfmt)                        b.dest = w[15:11];
        else if (ialu || ld || st || br) b.dest = w[20:16];
        else if (m == M_JAL)             b.dest = 5'd31;
        else                             b.dest = 5'd0;
        b.regwr     = ((rfmt && m != M_JR) || ialu || ld || m == M_JAL) && (b.dest != 5'd0);
        b.alusrc    = ialu || ld || st;
        b.memwr     = st;
        b.memtoreg  = ld;
        b.branch    = br;
        b.jump      = (m == M_J) || (m == M_JAL);
        b.jumpreg   = (m == M_JR) || (m == M_JALR);
        b.link      = (m == M_JAL) || (m == M_JALR);
        b.shamtctr  = m inside {M_SLL, M_SRL, M_SRA};
        b.dmsignext = (m == M_LB) || (m == M_LH);
        if (m inside {M_LB, M_LBU, M_SB})      b.bw = 2'b01;
        else if (m inside {M_LH, M_LHU, M_SH}) b.bw = 2'b10;
        else if (m inside {M_LW, M_SW})        b.bw = 2'b11;
        else                                   b.bw = 2'b00;
        b.ill = (m == M_ILL);
        urs = !(m inside {M_LUI, M_J, M_JAL, M_SLL, M_SRL, M_SRA});
        urt = ralu || shft || st || m == M_BEQ || m == M_BNE;
    endfunction

    function automatic bundle_t observed();
        bundle_t o;
        o.pc = out_pc; o.rs = out_rs; o.rt = out_rt; o.dest = out_dest; o.shamt = out_shamt;
        o.aluctr = out_aluctr; o.imm = out_imm; o.regwr = out_regwr; o.alusrc = out_alusrc;
        o.memwr = out_memwr; o.memtoreg = out_memtoreg; o.branch = out_branch; o.jump = out_jump;
        o.jumpreg = out_jumpreg; o.link = out_link; o.shamtctr = out_shamtctr;
        o.dmsignext = out_dmsignext; o.bw = out_bytewidth; o.ill = out_illegal;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock of traffic: drive, check in_ready, clock, advance model, check outputs
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy);
        bundle_t d;
        bit urs, urt, ld, hz, adv, exp_rdy;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        ref_decode(ins, pc, 1'b1, d, urs, urt, ld);
        hz = 1'b0;
        foreach (sbq[i])
            if (sbq[i] > 0 && ((urs && sbq[i] == int'(d.rs)) || (urt && sbq[i] == int'(d.rt))))
                hz = v;
        adv     = !m_valid || ordy;
        exp_rdy = adv && !hz && !fl;
        #1;
        seen_rdy = in_ready;
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        @(posedge clk);
        if (fl) begin
            m_valid = 1'b0;
            sbq[0]  = -1;
        end else if (adv) begin
            m_bundle = d;
            m_valid  = v && !hz;
            sbq.push_front((v && !hz && ld) ? int'(d.dest) : -1);
            void'(sbq.pop_back());
        end
        #1;
        chk("out_valid", 128'(out_valid), 128'(m_valid));
        if (m_valid) chk("bundle", 128'(observed()), 128'(m_bundle));
        $display("t=%0t instr=%h v=%0b fl=%0b ordy=%0b in_ready=%0b out_valid=%0b dest=%0d alu=%0d",
                 $time, ins, v, fl, ordy, seen_rdy, out_valid, out_dest, out_aluctr);
    endtask

    int fn_tab[18] = '{0, 2, 3, 4, 6, 7, 8, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
    int op_tab[23] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 32, 33, 35, 36, 37, 40, 41, 43};

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            logic [31:0] w;
            int k;
            k = $urandom_range(0, 9);
            w = $urandom;
            w[25:21] = 5'($urandom_range(0, 7));
            w[20:16] = 5'($urandom_range(0, 7));
            w[15:11] = 5'($urandom_range(0, 7));
            if (k < 4) begin
                w[31:26] = 6'd0;
                w[5:0]   = 6'(fn_tab[$urandom_range(0, 17)]);
            end else if (k < 9) begin
                w[31:26] = 6'(op_tab[$urandom_range(0, 22)]);
            end
            if (w[31:26] == 6'd1) w[20:16] = 5'($urandom_range(0, 2));
            cycle(($urandom_range(0, 3) != 0), w, $urandom,
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_valid   = 1'b0;
        m_bundle  = '0;
        sbq       = {-1};
        seen_rdy  = 1'b0;
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_bundle", 128'(observed()), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addu $3,$1,$2
        cycle(1, 32'h00221821, 32'h100, 0, 1);
        chk("addu_valid", 128'(out_valid), 128'(1));
        chk("addu_alu", 128'(out_aluctr), 128'(5'b00001));
        chk("addu_dest", 128'(out_dest), 128'(3));
        chk("addu_regwr", 128'(out_regwr), 128'(1));

        // lw $5,4($1) then dependent addu $6,$5,$2: one bubble
        cycle(1, 32'h8C250004, 32'h104, 0, 1);
        cycle(1, 32'h00A23021, 32'h108, 0, 1);
        chk("lu_stall_rdy", 128'(seen_rdy), 128'(0));
        chk("lu_bubble", 128'(out_valid), 128'(0));
        cycle(1, 32'h00A23021, 32'h108, 0, 1);
        chk("lu_issue_valid", 128'(out_valid), 128'(1));
        chk("lu_issue_dest", 128'(out_dest), 128'(6));

        // ori $7,$1,0xFF held three cycles while xori waits
        cycle(1, 32'h342700FF, 32'h10C, 0, 1);
        for (int h = 0; h < 3; h++) begin
            cycle(1, 32'h38481234, 32'h110, 0, 0);
            chk("hold_rdy", 128'(seen_rdy), 128'(0));
            chk("hold_imm", 128'(out_imm), 128'(32'h000000FF));
            chk("hold_pc", 128'(out_pc), 128'(32'h10C));
        end
        cycle(1, 32'h38481234, 32'h110, 0, 1);
        chk("release_imm", 128'(out_imm), 128'(32'h00001234));

        // lw $9 held, flush while beq $9,$2 waits
        cycle(1, 32'h8C290000, 32'h114, 0, 1);
        cycle(1, 32'h11220003, 32'h118, 1, 0);
        chk("flush_rdy", 128'(seen_rdy), 128'(0));
        chk("flush_kill", 128'(out_valid), 128'(0));
        cycle(1, 32'h11220003, 32'h118, 0, 1);
        chk("flush_nostall", 128'(seen_rdy), 128'(1));
        chk("beq_branch", 128'(out_branch), 128'(1));
        chk("beq_alu", 128'(out_aluctr), 128'(5'b01100));

        // jal and an unknown opcode
        cycle(1, 32'h0C000010, 32'h11C, 0, 1);
        chk("jal_jump", 128'(out_jump), 128'(1));
        chk("jal_link", 128'(out_link), 128'(1));
        chk("jal_dest", 128'(out_dest), 128'(31));
        chk("jal_regwr", 128'(out_regwr), 128'(1));
        cycle(1, 32'hFC000000, 32'h120, 0, 1);
        chk("op3f_illegal", 128'(out_illegal), 128'(1));
        chk("op3f_regwr", 128'(out_regwr), 128'(0));

        // lh $4,-2($1) with and without halfword support
        cycle(1, 32'h8424FFFE, 32'h124, 0, 1);
        chk("lh_bw", 128'(out_bytewidth), 128'(2'b10));
        chk("lh_sext", 128'(out_dmsignext), 128'(1));
        chk("lh_imm", 128'(out_imm), 128'(32'hFFFFFFFE));
        chk("lh_nohalf_ill", 128'(nh_out_illegal), 128'(1));
        chk("lh_nohalf_regwr", 128'(nh_out_regwr), 128'(0));

        random_cycles(400);

        // asynchronous reset between clock edges clears everything
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        chk("areset_valid", 128'(out_valid), 128'(0));
        chk("areset_bundle", 128'(observed()), 128'(0));
        m_valid  = 1'b0;
        m_bundle = '0;
        sbq      = {-1};
        #1;
        rst_n = 1'b1;

        random_cycles(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
